// File: rtl/cpu_rp2a03_apu_frame_counter_pkg.sv
// Shared APU constants: frame sequencer step positions, $4017 field layout,
// counter widths and small decode helpers.
package cpu_rp2a03_apu_frame_counter_pkg;

  localparam int CNT_W     = 16;
  localparam int RST_DLY_W = 3;

  localparam int STEP1_CYC = 7457;
  localparam int STEP2_CYC = 14913;
  localparam int STEP3_CYC = 22371;
  localparam int STEP4_CYC = 29829;
  localparam int STEP5_CYC = 37281;

  localparam int MODE_BIT        = 7;
  localparam int IRQ_INHIBIT_BIT = 6;

  typedef enum logic {
    MODE_4STEP = 1'b0,
    MODE_5STEP = 1'b1
  } fc_mode_e;

  typedef struct packed {
    fc_mode_e mode;
    logic     inhibit;
  } fc_ctrl_t;

  function automatic fc_ctrl_t decode_ctrl(input logic [7:0] data);
    fc_ctrl_t c;
    c.mode    = fc_mode_e'(data[MODE_BIT]);
    c.inhibit = data[IRQ_INHIBIT_BIT];
    return c;
  endfunction

  // A $4017 write lands 3 CPU cycles later on an even cycle, 4 on an odd one.
  function automatic logic [RST_DLY_W-1:0] restart_delay(input logic parity);
    return parity ? RST_DLY_W'(4) : RST_DLY_W'(3);
  endfunction

endpackage

// File: rtl/cpu_rp2a03_apu_frame_counter_if.sv
// CPU-side bus of the frame sequencer: cycle enable, $4017 write, $4015 read,
// and the strobes/IRQ it returns.
interface cpu_rp2a03_apu_frame_counter_if;
  logic       cpu_cycle_i;
  logic       frame_counter_wr_i;
  logic [7:0] frame_counter_wr_data_i;
  logic       status_rd_i;
  logic       quarter_frame_o;
  logic       half_frame_o;
  logic       frame_irq_o;

  modport master (
    output cpu_cycle_i, frame_counter_wr_i, frame_counter_wr_data_i, status_rd_i,
    input  quarter_frame_o, half_frame_o, frame_irq_o
  );

  modport slave (
    input  cpu_cycle_i, frame_counter_wr_i, frame_counter_wr_data_i, status_rd_i,
    output quarter_frame_o, half_frame_o, frame_irq_o
  );
endinterface

// File: rtl/cpu_rp2a03_apu_frame_counter.sv
// RP2A03 APU frame sequencer: CPU-cycle step counter, $4017 restart with
// parity-dependent delay, quarter/half-frame strobes and the frame IRQ flag.
module cpu_rp2a03_apu_frame_counter #(
  parameter int unsigned STEP1_CYC = cpu_rp2a03_apu_frame_counter_pkg::STEP1_CYC,
  parameter int unsigned STEP2_CYC = cpu_rp2a03_apu_frame_counter_pkg::STEP2_CYC,
  parameter int unsigned STEP3_CYC = cpu_rp2a03_apu_frame_counter_pkg::STEP3_CYC,
  parameter int unsigned STEP4_CYC = cpu_rp2a03_apu_frame_counter_pkg::STEP4_CYC,
  parameter int unsigned STEP5_CYC = cpu_rp2a03_apu_frame_counter_pkg::STEP5_CYC
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  cpu_rp2a03_apu_frame_counter_if.slave bus
);
  import cpu_rp2a03_apu_frame_counter_pkg::*;

  localparam logic [CNT_W-1:0] C_S1   = CNT_W'(STEP1_CYC);
  localparam logic [CNT_W-1:0] C_S2   = CNT_W'(STEP2_CYC);
  localparam logic [CNT_W-1:0] C_S3   = CNT_W'(STEP3_CYC);
  localparam logic [CNT_W-1:0] C_S4   = CNT_W'(STEP4_CYC);
  localparam logic [CNT_W-1:0] C_S4M1 = CNT_W'(STEP4_CYC - 1);
  localparam logic [CNT_W-1:0] C_S4P1 = CNT_W'(STEP4_CYC + 1);
  localparam logic [CNT_W-1:0] C_S5   = CNT_W'(STEP5_CYC);
  localparam logic [CNT_W-1:0] C_S5P1 = CNT_W'(STEP5_CYC + 1);

  logic [CNT_W-1:0]     cnt;
  fc_mode_e             mode;
  logic                 inhibit;
  logic                 irq;
  logic                 parity;
  logic                 pend;
  logic [RST_DLY_W-1:0] dly;
  logic                 quarter_q;
  logic                 half_q;

  fc_ctrl_t wr_ctrl;
  fc_mode_e mode_eff;
  logic     wr_en, rd_en, inh_eff, expire;
  logic     q_nxt, h_nxt, set_nxt, wrap_nxt, irq_nxt;

  always_comb begin
    wr_en    = bus.cpu_cycle_i & bus.frame_counter_wr_i;
    rd_en    = bus.cpu_cycle_i & bus.status_rd_i;
    wr_ctrl  = decode_ctrl(bus.frame_counter_wr_data_i);
    mode_eff = wr_en ? wr_ctrl.mode    : mode;
    inh_eff  = wr_en ? wr_ctrl.inhibit : inhibit;
    // A fresh write reloads the delay, so it pre-empts an expiry in the same cycle.
    expire   = pend & (dly == RST_DLY_W'(1)) & ~wr_en;

    q_nxt    = 1'b0;
    h_nxt    = 1'b0;
    set_nxt  = 1'b0;
    wrap_nxt = 1'b0;
    if (expire) begin
      q_nxt = (mode_eff == MODE_5STEP);
      h_nxt = (mode_eff == MODE_5STEP);
    end else if (mode_eff == MODE_4STEP) begin
      q_nxt    = (cnt == C_S1) | (cnt == C_S2) | (cnt == C_S3) | (cnt == C_S4);
      h_nxt    = (cnt == C_S2) | (cnt == C_S4);
      set_nxt  = (cnt >= C_S4M1) & (cnt <= C_S4P1);
      wrap_nxt = (cnt == C_S4P1);
    end else begin
      q_nxt    = (cnt == C_S1) | (cnt == C_S2) | (cnt == C_S3) | (cnt == C_S5);
      h_nxt    = (cnt == C_S2) | (cnt == C_S5);
      wrap_nxt = (cnt == C_S5P1);
    end

    // Set beats clear when both land in the same CPU cycle.
    irq_nxt = irq;
    if (set_nxt & ~inh_eff)
      irq_nxt = 1'b1;
    else if (rd_en | (wr_en & inh_eff))
      irq_nxt = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt       <= '0;
      mode      <= MODE_4STEP;
      inhibit   <= 1'b0;
      irq       <= 1'b0;
      parity    <= 1'b0;
      pend      <= 1'b0;
      dly       <= '0;
      quarter_q <= 1'b0;
      half_q    <= 1'b0;
    end else begin
      quarter_q <= 1'b0;
      half_q    <= 1'b0;
      if (bus.cpu_cycle_i) begin
        quarter_q <= q_nxt;
        half_q    <= h_nxt;
        parity    <= ~parity;
        mode      <= mode_eff;
        inhibit   <= inh_eff;
        irq       <= irq_nxt;
        cnt       <= (expire | wrap_nxt) ? '0 : cnt + 1'b1;
        if (wr_en) begin
          pend <= 1'b1;
          dly  <= restart_delay(parity);
        end else if (pend) begin
          if (dly == RST_DLY_W'(1))
            pend <= 1'b0;
          dly <= dly - 1'b1;
        end
      end
    end
  end

  assign bus.quarter_frame_o = quarter_q;
  assign bus.half_frame_o    = half_q;
  assign bus.frame_irq_o     = irq;

endmodule
